// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field widths, bias, canonical NaN and operand class enum
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [31:0]      CANON_NAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - binary32 field split and operand classification
//
// Ports:
//   val  : binary32 operand
//   sign : sign bit
//   exp  : biased exponent field
//   sig  : 24-bit significand with hidden bit (hidden bit 0 for zero/subnormal)
//   cls  : operand class; subnormals are reported as ZERO (flush-to-zero)
import fp32_pkg::*;

module fp32_unpack (
  input  logic [31:0]      val,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output fp_class_e        cls
);

  logic [FRAC_W-1:0] frac;

  assign sign = val[EXP_W+FRAC_W];
  assign exp  = val[FRAC_W +: EXP_W];
  assign frac = val[FRAC_W-1:0];
  assign sig  = {(exp != '0), frac};

  always_comb begin
    cls = NORM;
    if (exp == '0) begin
      cls = ZERO;
    end else if (exp == EXP_MAX) begin
      if (frac == '0)
        cls = INF;
      else if (frac[FRAC_W-1])
        cls = QNAN;
      else
        cls = SNAN;
    end
  end

endmodule

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - two-stage pipelined binary32 multiplier, RNE, flush-to-zero
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : mul1/mul2 carry a valid operand pair
//   mul1      : binary32 operand A
//   mul2      : binary32 operand B
//   out_valid : product/flags valid (in_valid delayed two stages)
//   product   : binary32 result A*B, held while out_valid=0
//   flags     : {invalid, overflow, underflow, inexact}
import fp32_pkg::*;

module fp32_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] mul1,
  input  logic [31:0] mul2,
  output logic        out_valid,
  output logic [31:0] product,
  output logic [3:0]  flags
);

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [SIG_W-1:0] ma, mb;
  fp_class_e        ca, cb;

  fp32_unpack u_unpack_a (.val(mul1), .sign(sa), .exp(ea), .sig(ma), .cls(ca));
  fp32_unpack u_unpack_b (.val(mul2), .sign(sb), .exp(eb), .sig(mb), .cls(cb));

  // Stage 1: special-case decode, exponent sum, significand product
  logic        spec;
  logic [31:0] spec_prod;
  logic [3:0]  spec_flags;
  logic        sgn;
  logic [9:0]  exp_sum;
  logic [47:0] sig_prod;

  assign sgn      = sa ^ sb;
  // Unbiased-once sum kept as 10-bit two's complement: range -125..381
  assign exp_sum  = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
  assign sig_prod = {24'b0, ma} * {24'b0, mb};

  always_comb begin
    spec       = 1'b1;
    spec_prod  = '0;
    spec_flags = '0;
    if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
      spec_prod  = CANON_NAN;
      spec_flags = {(ca == SNAN || cb == SNAN), 3'b000};
    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      spec_prod  = CANON_NAN;
      spec_flags = 4'b1000;
    end else if (ca == INF || cb == INF) begin
      spec_prod  = {sgn, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      spec_prod  = {sgn, {(EXP_W+FRAC_W){1'b0}}};
    end else begin
      spec       = 1'b0;
    end
  end

  logic        s1_valid;
  logic        s1_spec;
  logic [31:0] s1_spec_prod;
  logic [3:0]  s1_spec_flags;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic [47:0] s1_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_spec       <= 1'b0;
      s1_spec_prod  <= '0;
      s1_spec_flags <= '0;
      s1_sign       <= 1'b0;
      s1_exp        <= '0;
      s1_prod       <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_spec       <= spec;
        s1_spec_prod  <= spec_prod;
        s1_spec_flags <= spec_flags;
        s1_sign       <= sgn;
        s1_exp        <= exp_sum;
        s1_prod       <= sig_prod;
      end
    end
  end

  // Stage 2: normalize, round to nearest even, range check, pack
  logic [SIG_W-1:0]  mant;
  logic              grd, sticky, round_up;
  logic [SIG_W:0]    mant_r;
  logic signed [9:0] exp_r;
  logic [FRAC_W-1:0] frac_r;
  logic [31:0]       res_prod;
  logic [3:0]        res_flags;

  always_comb begin
    if (s1_prod[47]) begin
      mant   = s1_prod[47:24];
      grd    = s1_prod[23];
      sticky = |s1_prod[22:0];
    end else begin
      mant   = s1_prod[46:23];
      grd    = s1_prod[22];
      sticky = |s1_prod[21:0];
    end
    round_up = grd & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    // A carry out of rounding leaves 1.000..0, so the shifted fraction is zero
    frac_r   = mant_r[SIG_W] ? mant_r[SIG_W-1:1] : mant_r[FRAC_W-1:0];
    exp_r    = s1_exp + {9'b0, s1_prod[47]} + {9'b0, mant_r[SIG_W]};

    res_prod  = '0;
    res_flags = '0;
    if (s1_spec) begin
      res_prod  = s1_spec_prod;
      res_flags = s1_spec_flags;
    end else if (exp_r >= 10'sd255) begin
      res_prod  = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
      res_flags = 4'b0101;
    end else if (exp_r <= 10'sd0) begin
      res_prod  = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
      res_flags = 4'b0011;
    end else begin
      res_prod  = {s1_sign, exp_r[EXP_W-1:0], frac_r};
      res_flags = {3'b000, grd | sticky};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      flags     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        product <= res_prod;
        flags   <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul.sv
// tb/tb_fp32_mul.sv - self-checking bench for fp32_mul against an arithmetic reference
module tb_fp32_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] mul1;
  logic [31:0] mul2;
  logic        out_valid;
  logic [31:0] product;
  logic [3:0]  flags;

  int n_cmp;
  int n_bad;

  fp32_mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mul1(mul1), .mul2(mul2),
    .out_valid(out_valid), .product(product), .flags(flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: returns {flags, product}. Finite products are formed exactly as
  // integers and rounded by comparing the discarded remainder with one half ulp.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned pa, pb, p, kept, rem, half;
    int msb, sh, e;
    logic inexact;
    sign   = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan)
      return {(a_snan || b_snan), 3'b000, 32'h7FC00000};
    if ((a_inf && b_zero) || (b_inf && a_zero))
      return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf)
      return {4'b0000, sign, 8'hFF, 23'h0};
    if (a_zero || b_zero)
      return {4'b0000, sign, 31'h0};
    pa   = {40'h0, 1'b1, a[22:0]};
    pb   = {40'h0, 1'b1, b[22:0]};
    p    = pa * pb;
    msb  = p[47] ? 47 : 46;
    sh   = msb - 23;
    kept = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    e    = int'(a[30:23]) + int'(b[30:23]) - 127 + (msb - 46);
    inexact = (rem != 0);
    if (rem > half || (rem == half && kept[0]))
      kept = kept + 1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e >= 255)
      return {4'b0101, sign, 8'hFF, 23'h0};
    if (e <= 0)
      return {4'b0011, sign, 31'h0};
    return {3'b000, inexact, sign, e[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 19);
    v = $urandom;
    case (r)
      0:       v = {v[31], 31'h0};
      1:       v = {v[31], 8'h00, v[22:0] | 23'h1};
      2:       v = {v[31], 8'hFF, 23'h0};
      3:       v = {v[31], 8'hFF, 1'b1, v[21:0]};
      4:       v = {v[31], 8'hFF, 1'b0, v[21:0] | 22'h1};
      5, 6, 7, 8, 9, 10, 11, 12:
               v = {v[31], 8'($urandom_range(100, 154)), v[22:0]};
      default: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mul1 = '0; mul2 = '0;
    #2;
    n_cmp++;
    if ({out_valid, product, flags} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b p=%h f=%b, want all zero", out_valid, product, flags);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'h40800000, 32'h3FC00000, 32'h420098BA, 32'h7F800000, 32'h7F000000};
    logic [31:0] tb [5] = '{32'h40000000, 32'h3FC00000, 32'h48004ABC, 32'h00000000, 32'h7F000000};
    logic [31:0] tp [5] = '{32'h41000000, 32'h40100000, 32'h4A80E3CF, 32'h7FC00000, 32'h7F800000};
    logic [3:0]  tf [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      mul1 = ta[i]; mul2 = tb[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL directed%0d_early: out_valid=%b after 1 edge, want 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, product, flags} !== {1'b1, tp[i], tf[i]}) begin
        n_bad++;
        $display("FAIL directed%0d: got v=%b p=%h f=%b, want v=1 p=%h f=%b",
                 i, out_valid, product, flags, tp[i], tf[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [35:0] e;
    for (int i = 0; i < 4; i++) begin
      a[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (c >= 2 && c <= 5) begin
        e = model(a[c-2], b[c-2]);
        if ({out_valid, product, flags} !== {1'b1, e[31:0], e[35:32]}) begin
          n_bad++;
          $display("FAIL b2b%0d: got v=%b p=%h f=%b, want v=1 p=%h f=%b",
                   c - 2, out_valid, product, flags, e[31:0], e[35:32]);
        end
      end else if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle%0d: out_valid=%b, want 0", c, out_valid);
      end
      if (c < 4) begin
        mul1 = a[c]; mul2 = b[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] e;
    for (int i = 0; i < 3; i++) begin
      mul1 = 32'h40400000; mul2 = 32'h40A00000; in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, product, flags} !== 37'h0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b p=%h f=%b, want all zero", out_valid, product, flags);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flushed%0d: out_valid=%b, want 0", c, out_valid);
      end
    end
    mul1 = 32'hC0400000; mul2 = 32'h3F000000; in_valid = 1'b1;
    e = model(mul1, mul2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, product, flags} !== {1'b1, e[31:0], e[35:32]}) begin
      n_bad++;
      $display("FAIL post_reset: got v=%b p=%h f=%b, want v=1 p=%h f=%b",
               out_valid, product, flags, e[31:0], e[35:32]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [36:0] q[$];
    logic [36:0] e;
    logic [31:0] a, b;
    logic        v;
    logic [36:0] last;
    q.push_back(37'h0);
    q.push_back(37'h0);
    last = 37'h0;
    for (int c = 0; c < 400; c++) begin
      e = q.pop_front();
      n_cmp++;
      if (out_valid !== e[36]) begin
        n_bad++;
        $display("FAIL rand%0d_valid: out_valid=%b, want %b", c, out_valid, e[36]);
      end else if (e[36] && {product, flags} !== {e[31:0], e[35:32]}) begin
        n_bad++;
        $display("FAIL rand%0d: got p=%h f=%b, want p=%h f=%b",
                 c, product, flags, e[31:0], e[35:32]);
      end else if (!e[36] && last[36] && {product, flags} !== {last[31:0], last[35:32]}) begin
        n_bad++;
        $display("FAIL rand%0d_hold: got p=%h f=%b, want p=%h f=%b",
                 c, product, flags, last[31:0], last[35:32]);
      end
      if (e[36]) last = e;
      v = ($urandom_range(0, 3) != 0);
      a = gen_operand();
      b = gen_operand();
      q.push_back({v, model(a, b)});
      mul1 = a; mul2 = b; in_valid = v;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
